// File: rtl/rv_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rv_multicycle_ctrl
// Description : Multi-cycle control FSM for an RV32I core. Sequences one
//               instruction at a time through FETCH, DECODE, EXEC, MEM and WB.
//               The FSM drives immediate-format select, ALU operand/op
//               selects, data-memory request, register-file write, write-back
//               mux and PC-update controls for a shared datapath.
// Ports       : clk, reset            - clock, async active-high reset
//               inst_code             - instruction register contents
//               imem_ready/dmem_ready - memory handshakes
//               br_taken              - branch compare result (EXEC)
//               imem_req, ir_write    - fetch controls
//               imm_sel               - 0 none,1 I,2 S,3 B,4 U,5 J
//               alu_src_a/b, alu_op   - ALU controls
//               dmem_req, dmem_we     - data memory controls
//               reg_write, wb_sel     - register write-back controls
//               pc_write, pc_src      - PC update controls
//               state, illegal        - debug state, sticky illegal flag
//               instret               - retired-instruction counter
// Revision    : 1.0 - initial release
// ============================================================================
module rv_multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst_code,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        br_taken,
    output logic        imem_req,
    output logic        ir_write,
    output logic [2:0]  imm_sel,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [2:0]  state,
    output logic        illegal,
    output logic [31:0] instret
);

    // State encoding
    localparam logic [2:0] c_st_fetch  = 3'd0;
    localparam logic [2:0] c_st_decode = 3'd1;
    localparam logic [2:0] c_st_exec   = 3'd2;
    localparam logic [2:0] c_st_mem    = 3'd3;
    localparam logic [2:0] c_st_wb     = 3'd4;
    localparam logic [2:0] c_st_trap   = 3'd5;

    // Opcodes
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_opimm  = 7'b0010011;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_op     = 7'b0110011;

    // Immediate formats
    localparam logic [2:0] c_imm_none = 3'd0;
    localparam logic [2:0] c_imm_i    = 3'd1;
    localparam logic [2:0] c_imm_s    = 3'd2;
    localparam logic [2:0] c_imm_b    = 3'd3;
    localparam logic [2:0] c_imm_u    = 3'd4;
    localparam logic [2:0] c_imm_j    = 3'd5;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic        r_illegal;
    logic [31:0] r_instret;

    logic [6:0]  w_opcode;
    logic        w_rd_nonzero;
    logic        w_is_load, w_is_opimm, w_is_jalr, w_is_store, w_is_branch;
    logic        w_is_lui, w_is_auipc, w_is_jal, w_is_op, w_legal;
    logic [2:0]  w_imm_fmt;
    logic        w_unused;

    // ------------------------------------------------------------------
    // Opcode decode
    // ------------------------------------------------------------------
    assign w_opcode     = inst_code[6:0];
    assign w_rd_nonzero = (inst_code[11:7] != 5'd0);
    assign w_unused     = ^inst_code[31:12];

    assign w_is_load   = (w_opcode == c_op_load);
    assign w_is_opimm  = (w_opcode == c_op_opimm);
    assign w_is_jalr   = (w_opcode == c_op_jalr);
    assign w_is_store  = (w_opcode == c_op_store);
    assign w_is_branch = (w_opcode == c_op_branch);
    assign w_is_lui    = (w_opcode == c_op_lui);
    assign w_is_auipc  = (w_opcode == c_op_auipc);
    assign w_is_jal    = (w_opcode == c_op_jal);
    assign w_is_op     = (w_opcode == c_op_op);

    assign w_legal = w_is_load | w_is_opimm | w_is_jalr | w_is_store |
                     w_is_branch | w_is_lui | w_is_auipc | w_is_jal | w_is_op;

    always_comb begin
        w_imm_fmt = c_imm_none;
        if (w_is_load || w_is_opimm || w_is_jalr) begin
            w_imm_fmt = c_imm_i;
        end else if (w_is_store) begin
            w_imm_fmt = c_imm_s;
        end else if (w_is_branch) begin
            w_imm_fmt = c_imm_b;
        end else if (w_is_lui || w_is_auipc) begin
            w_imm_fmt = c_imm_u;
        end else if (w_is_jal) begin
            w_imm_fmt = c_imm_j;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_fetch;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = c_st_fetch;
        case (r_state)
            c_st_fetch: begin
                w_next_state = imem_ready ? c_st_decode : c_st_fetch;
            end
            c_st_decode: begin
                w_next_state = w_legal ? c_st_exec : c_st_trap;
            end
            c_st_exec: begin
                if (w_is_load || w_is_store) begin
                    w_next_state = c_st_mem;
                end else if (w_is_branch) begin
                    w_next_state = c_st_fetch;
                end else begin
                    w_next_state = c_st_wb;
                end
            end
            c_st_mem: begin
                if (!dmem_ready) begin
                    w_next_state = c_st_mem;
                end else if (w_is_store) begin
                    w_next_state = c_st_fetch;
                end else begin
                    w_next_state = c_st_wb;
                end
            end
            c_st_wb: begin
                w_next_state = c_st_fetch;
            end
            c_st_trap: begin
                w_next_state = c_st_trap;
            end
            // Unused encodings recover to FETCH.
            default: begin
                w_next_state = c_st_fetch;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic. Everything is held low while reset is asserted so the
    // datapath sees no spurious request during the asynchronous reset.
    // ------------------------------------------------------------------
    always_comb begin
        imem_req  = 1'b0;
        ir_write  = 1'b0;
        imm_sel   = c_imm_none;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        alu_op    = 2'd0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 2'd0;
        pc_write  = 1'b0;
        pc_src    = 2'd0;
        if (!reset) begin
            case (r_state)
                c_st_fetch: begin
                    imem_req = 1'b1;
                    ir_write = imem_ready;
                end
                c_st_decode: begin
                    imm_sel = w_imm_fmt;
                end
                c_st_exec: begin
                    imm_sel = w_imm_fmt;
                    if (w_is_load || w_is_store || w_is_jalr) begin
                        alu_src_b = 1'b1;
                        alu_op    = 2'd0;
                    end else if (w_is_branch) begin
                        alu_op   = 2'd1;
                        pc_write = 1'b1;
                        pc_src   = br_taken ? 2'd1 : 2'd0;
                    end else if (w_is_op) begin
                        alu_op = 2'd2;
                    end else if (w_is_opimm) begin
                        alu_src_b = 1'b1;
                        alu_op    = 2'd2;
                    end else if (w_is_lui) begin
                        alu_src_b = 1'b1;
                        alu_op    = 2'd3;
                    end else if (w_is_auipc) begin
                        alu_src_a = 1'b1;
                        alu_src_b = 1'b1;
                        alu_op    = 2'd0;
                    end
                    // JAL: PC+imm and PC+4 come from dedicated adders.
                end
                c_st_mem: begin
                    imm_sel  = w_imm_fmt;
                    dmem_req = 1'b1;
                    dmem_we  = w_is_store;
                    // A store retires on the cycle its access completes.
                    pc_write = w_is_store & dmem_ready;
                end
                c_st_wb: begin
                    imm_sel   = w_imm_fmt;
                    reg_write = w_rd_nonzero;
                    if (w_is_load) begin
                        wb_sel = 2'd1;
                    end else if (w_is_jal || w_is_jalr) begin
                        wb_sel = 2'd2;
                    end
                    pc_write = 1'b1;
                    if (w_is_jal) begin
                        pc_src = 2'd1;
                    end else if (w_is_jalr) begin
                        pc_src = 2'd2;
                    end
                end
                default: begin
                    // TRAP and unused encodings drive nothing.
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky illegal flag and retired-instruction counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_illegal <= 1'b0;
        end else if (w_next_state == c_st_trap) begin
            r_illegal <= 1'b1;
        end
    end

    // Every retirement is marked by exactly one pc_write cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instret <= 32'd0;
        end else if (pc_write) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    assign state   = r_state;
    assign illegal = r_illegal;
    assign instret = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_rv_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_multicycle_ctrl
// Description : Self-checking bench for rv_multicycle_ctrl. Directed vector
//               table, randomized instruction stream against an
//               instruction-level expected-cycle model, and hand sequences
//               for trap, counter wrap and reset in the middle of a load.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inst_code;
    logic        imem_ready, dmem_ready, br_taken;
    logic        imem_req, ir_write;
    logic [2:0]  imm_sel;
    logic        alu_src_a, alu_src_b;
    logic [1:0]  alu_op;
    logic        dmem_req, dmem_we, reg_write;
    logic [1:0]  wb_sel;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic [2:0]  state;
    logic        illegal;
    logic [31:0] instret;

    rv_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .inst_code(inst_code),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .br_taken(br_taken),
        .imem_req(imem_req), .ir_write(ir_write), .imm_sel(imm_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write(reg_write),
        .wb_sel(wb_sel), .pc_write(pc_write), .pc_src(pc_src),
        .state(state), .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       imem_req;
        logic       ir_write;
        logic [2:0] imm_sel;
        logic       a;
        logic       b;
        logic [1:0] op;
        logic       dreq;
        logic       dwe;
        logic       rw;
        logic [1:0] wb;
        logic       pcw;
        logic [1:0] pcs;
        logic [2:0] st;
        logic       ill;
    } ctl_t;

    typedef struct {
        ctl_t e;
        bit   ir;
        bit   dr;
    } step_t;

    typedef struct {
        logic [31:0] inst;
        bit          br;
        int          wf;
        int          wd;
        int          cyc;
        logic [2:0]  imm;
        logic        rw;
        logic [1:0]  wb;
        logic [1:0]  pcs;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_instret;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic ctl_t act_ctl();
        ctl_t c;
        c.imem_req = imem_req; c.ir_write = ir_write; c.imm_sel = imm_sel;
        c.a = alu_src_a; c.b = alu_src_b; c.op = alu_op;
        c.dreq = dmem_req; c.dwe = dmem_we; c.rw = reg_write; c.wb = wb_sel;
        c.pcw = pc_write; c.pcs = pc_src; c.st = state; c.ill = illegal;
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Instruction-level model: expands one instruction (with its fetch and
    // data wait counts) into the sequence of control words the controller
    // must present, then drives and checks it cycle by cycle.
    task automatic run_inst(input logic [31:0] inst, input bit br, input int wf, input int wd);
        step_t      q[$];
        step_t      s;
        ctl_t       z;
        logic [6:0] opc;
        logic [2:0] fmt;
        bit ld, sw, bq, jl, jr, rr, ri, lu, au;
        opc = inst[6:0];
        ld = (opc == 7'h03); ri = (opc == 7'h13); jr = (opc == 7'h67);
        sw = (opc == 7'h23); bq = (opc == 7'h63); lu = (opc == 7'h37);
        au = (opc == 7'h17); jl = (opc == 7'h6F); rr = (opc == 7'h33);
        fmt = (ld || ri || jr) ? 3'd1 : sw ? 3'd2 : bq ? 3'd3 :
              (lu || au) ? 3'd4 : jl ? 3'd5 : 3'd0;
        z = '0;
        for (int i = 0; i <= wf; i++) begin
            s.e = z; s.e.imem_req = 1'b1; s.e.ir_write = (i == wf); s.e.st = 3'd0;
            s.ir = (i == wf); s.dr = 1'($urandom);
            q.push_back(s);
        end
        s.e = z; s.e.st = 3'd1; s.e.imm_sel = fmt;
        s.ir = 1'($urandom); s.dr = 1'($urandom);
        q.push_back(s);
        s.e = z; s.e.st = 3'd2; s.e.imm_sel = fmt;
        s.ir = 1'($urandom); s.dr = 1'($urandom);
        if (ld || sw || jr || ri || lu || au) s.e.b = 1'b1;
        if (au) s.e.a = 1'b1;
        if (rr || ri) s.e.op = 2'd2;
        if (lu) s.e.op = 2'd3;
        if (bq) begin s.e.op = 2'd1; s.e.pcw = 1'b1; s.e.pcs = {1'b0, br}; end
        q.push_back(s);
        if (ld || sw) begin
            for (int i = 0; i <= wd; i++) begin
                s.e = z; s.e.st = 3'd3; s.e.imm_sel = fmt;
                s.e.dreq = 1'b1; s.e.dwe = sw; s.e.pcw = sw && (i == wd);
                s.ir = 1'($urandom); s.dr = (i == wd);
                q.push_back(s);
            end
        end
        if (!bq && !sw) begin
            s.e = z; s.e.st = 3'd4; s.e.imm_sel = fmt;
            s.e.rw = (inst[11:7] != 5'd0);
            s.e.wb = ld ? 2'd1 : (jl || jr) ? 2'd2 : 2'd0;
            s.e.pcw = 1'b1;
            s.e.pcs = jl ? 2'd1 : jr ? 2'd2 : 2'd0;
            s.ir = 1'($urandom); s.dr = 1'($urandom);
            q.push_back(s);
        end
        br_taken = br;
        for (int k = 0; k < q.size(); k++) begin
            if (k == wf + 1) inst_code = inst;
            imem_ready = q[k].ir;
            dmem_ready = q[k].dr;
            #1;
            chk("ctl", 64'(act_ctl()), 64'(q[k].e));
            chk("instret", 64'(instret), 64'(m_instret));
            tick();
            if (q[k].e.pcw) m_instret = m_instret + 32'd1;
        end
    endtask

    // Memory-responder run used by the vector table: counts cycles from the
    // first FETCH cycle to the retiring pc_write cycle and captures controls.
    task automatic run_meas(input vec_t v);
        int fc = 0, dc = 0, cyc = 0;
        bit done = 0;
        logic [2:0] c_imm = '0;
        logic c_rw = 0;
        logic [1:0] c_wb = '0, c_pcs = '0;
        inst_code = v.inst;
        br_taken  = v.br;
        while (!done && cyc < 50) begin
            imem_ready = imem_req && (fc >= v.wf);
            if (imem_req) fc++;
            dmem_ready = dmem_req && (dc >= v.wd);
            if (dmem_req) dc++;
            #1;
            cyc++;
            if (pc_write) begin
                done = 1; c_imm = imm_sel; c_rw = reg_write; c_wb = wb_sel; c_pcs = pc_src;
            end
            tick();
        end
        if (!done) chk("vec_timeout", 64'(cyc), 64'(0));
        m_instret = m_instret + 32'd1;
        chk("vec_cycles",  64'(cyc),     64'(v.cyc));
        chk("vec_imm_sel", 64'(c_imm),   64'(v.imm));
        chk("vec_reg_wr",  64'(c_rw),    64'(v.rw));
        chk("vec_wb_sel",  64'(c_wb),    64'(v.wb));
        chk("vec_pc_src",  64'(c_pcs),   64'(v.pcs));
        chk("vec_instret", 64'(instret), 64'(m_instret));
    endtask

    task automatic run_random(input int n);
        logic [6:0]  ops [9];
        logic [31:0] inst;
        ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
        for (int i = 0; i < n; i++) begin
            inst = $urandom;
            inst[6:0] = ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 3) == 0) inst[11:7] = 5'd0;
            run_inst(inst, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    vec_t vt[13];
    ctl_t exp_c;
    bit   seen_pcw;
    int   mem_cyc;

    initial begin
        vt[0]  = '{32'h00500093, 0, 0, 0, 4, 3'd1, 1'b1, 2'd0, 2'd0}; // ADDI x1
        vt[1]  = '{32'h00112223, 0, 0, 2, 6, 3'd2, 1'b0, 2'd0, 2'd0}; // SW, 2 waits
        vt[2]  = '{32'h00000463, 1, 0, 0, 3, 3'd3, 1'b0, 2'd0, 2'd1}; // BEQ taken
        vt[3]  = '{32'h00000463, 0, 0, 0, 3, 3'd3, 1'b0, 2'd0, 2'd0}; // BEQ not taken
        vt[4]  = '{32'h008000EF, 0, 0, 0, 4, 3'd5, 1'b1, 2'd2, 2'd1}; // JAL x1
        vt[5]  = '{32'h0080006F, 0, 0, 0, 4, 3'd5, 1'b0, 2'd2, 2'd1}; // JAL x0
        vt[6]  = '{32'h00002083, 0, 0, 0, 5, 3'd1, 1'b1, 2'd1, 2'd0}; // LW x1
        vt[7]  = '{32'h000100E7, 0, 0, 0, 4, 3'd1, 1'b1, 2'd2, 2'd2}; // JALR x1
        vt[8]  = '{32'h123452B7, 0, 0, 0, 4, 3'd4, 1'b1, 2'd0, 2'd0}; // LUI x5
        vt[9]  = '{32'h00000197, 0, 0, 0, 4, 3'd4, 1'b1, 2'd0, 2'd0}; // AUIPC x3
        vt[10] = '{32'h002081B3, 0, 0, 0, 4, 3'd0, 1'b1, 2'd0, 2'd0}; // ADD x3
        vt[11] = '{32'h00500093, 0, 2, 0, 6, 3'd1, 1'b1, 2'd0, 2'd0}; // ADDI, fetch waits
        vt[12] = '{32'h00002083, 0, 1, 1, 7, 3'd1, 1'b1, 2'd1, 2'd0}; // LW, both waits

        reset = 1'b1; inst_code = 32'h0; imem_ready = 1'b1; dmem_ready = 1'b1; br_taken = 1'b0;
        m_instret = 32'd0;
        #1;
        chk("reset_ctl", 64'(act_ctl()), 64'(ctl_t'('0)));
        chk("reset_instret", 64'(instret), 64'(0));
        @(negedge clk);
        @(negedge clk);
        imem_ready = 1'b0;
        reset = 1'b0;
        #1;
        chk("release_imem_req", 64'({imem_req, state}), 64'({1'b1, 3'd0}));
        tick();

        // Directed vectors
        for (int i = 0; i < 13; i++) run_meas(vt[i]);

        // Counter wrap: preload all-ones while stalled in FETCH
        imem_ready = 1'b0;
        force dut.r_instret = 32'hFFFF_FFFF;
        #1;
        release dut.r_instret;
        tick();
        m_instret = 32'hFFFF_FFFF;
        chk("wrap_preload", 64'(instret), 64'(32'hFFFF_FFFF));
        run_inst(32'h00500093, 1'b0, 0, 0);
        chk("wrap_zero", 64'(instret), 64'(0));

        // Randomized stream
        run_random(150);

        // Illegal opcode trap
        inst_code = 32'h0000007F;
        imem_ready = 1'b1;
        #1;
        chk("trap_fetch", 64'({imem_req, ir_write}), 64'(2'b11));
        tick();
        #1;
        exp_c = '0; exp_c.st = 3'd1;
        chk("trap_decode", 64'(act_ctl()), 64'(exp_c));
        tick();
        exp_c = '0; exp_c.st = 3'd5; exp_c.ill = 1'b1;
        for (int i = 0; i < 20; i++) begin
            imem_ready = 1'($urandom); dmem_ready = 1'($urandom); br_taken = 1'($urandom);
            #1;
            chk("trap_hold", 64'(act_ctl()), 64'(exp_c));
            chk("trap_instret", 64'(instret), 64'(m_instret));
            tick();
        end
        imem_ready = 1'b1;
        reset = 1'b1;
        #1;
        chk("trap_reset_ctl", 64'(act_ctl()), 64'(ctl_t'('0)));
        chk("trap_reset_instret", 64'(instret), 64'(0));
        @(negedge clk);
        imem_ready = 1'b0;
        reset = 1'b0;
        m_instret = 32'd0;
        tick();

        run_random(20);

        // Reset while a load waits in MEM
        inst_code = 32'h00002083;
        br_taken = 1'b0;
        seen_pcw = 0;
        mem_cyc = 0;
        for (int i = 0; i < 30 && mem_cyc < 3; i++) begin
            imem_ready = imem_req;
            dmem_ready = 1'b0;
            #1;
            if (pc_write) seen_pcw = 1;
            if (state == 3'd3) mem_cyc++;
            tick();
        end
        chk("midload_reached_mem", 64'(mem_cyc), 64'(3));
        chk("midload_instret_hold", 64'(instret), 64'(m_instret));
        #1;
        reset = 1'b1;
        #1;
        if (pc_write) seen_pcw = 1;
        chk("midload_no_pcw", 64'(seen_pcw), 64'(0));
        chk("midload_reset", 64'({state, illegal, instret}), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        m_instret = 32'd0;
        #1;
        chk("midload_release", 64'({imem_req, state, instret}), 64'({1'b1, 3'd0, 32'd0}));
        tick();
        run_inst(32'h00500093, 1'b0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/rv_multicycle_ctrl.md
# rv_multicycle_ctrl

Multi-cycle control FSM for the RV32I core. It sequences one instruction at a time through fetch, decode, execute, memory and write-back. Each step drives the immediate-format select for the immediate generator, plus ALU, memory, register-file and PC-update controls. It sits between the instruction register / memory handshakes and the shared datapath, so one ALU and memory port serve every instruction class.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- inst_code  in  32  instruction register output; stable from DECODE until the next FETCH completes
- imem_ready  in  1  instruction memory: data valid this cycle
- dmem_ready  in  1  data memory: access complete this cycle
- br_taken  in  1  ALU branch-compare result, valid in EXEC
- imem_req  out  1  instruction fetch request
- ir_write  out  1  load inst_code register
- imm_sel  out  3  0 none, 1 I, 2 S, 3 B, 4 U, 5 J
- alu_src_a  out  1  0 rs1, 1 PC
- alu_src_b  out  1  0 rs2, 1 immediate
- alu_op  out  2  0 add, 1 branch compare, 2 funct3/funct7 decoded, 3 pass B
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write enable (store)
- reg_write  out  1  register-file write enable
- wb_sel  out  2  0 ALU, 1 memory data, 2 PC+4
- pc_write  out  1  update PC this cycle
- pc_src  out  2  0 PC+4, 1 PC+imm, 2 (ALU result & ~1)
- state  out  3  current state, for debug
- illegal  out  1  sticky illegal-opcode flag
- instret  out  32  retired-instruction counter

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 go to FETCH.
- Opcode classes:
  - LOAD 0000011 and OPIMM 0010011 → I.
  - JALR 1100111 → I.
  - STORE 0100011 → S.
  - BRANCH 1100011 → B.
  - LUI 0110111 and AUIPC 0010111 → U.
  - JAL 1101111 → J.
  - OP 0110011 → none.
  - Any other opcode is illegal.
- FETCH:
  - imem_req=1.
  - When imem_ready=1: ir_write=1 in the same cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - imm_sel is driven from inst_code[6:0]; it stays driven for the rest of the instruction.
  - Illegal opcode → TRAP. Otherwise → EXEC.
- EXEC:
  - LOAD/STORE: alu_src_b=1, alu_op=0, then go to MEM.
  - BRANCH:
    - Controls: alu_op=1, pc_write=1.
    - pc_src=1 if br_taken, else 0.
    - Then go to FETCH (instruction retires).
  - OP: alu_op=2. OPIMM: alu_src_b=1, alu_op=2.
  - LUI: alu_src_b=1, alu_op=3. AUIPC: alu_src_a=1, alu_src_b=1, alu_op=0.
  - JAL: no ALU use. JALR: alu_src_b=1, alu_op=0.
  - Every class except LOAD/STORE/BRANCH then goes to WB.
- MEM:
  - dmem_req=1; dmem_we=1 for STORE.
  - Wait for dmem_ready.
  - STORE: pc_write=1, pc_src=0, then go to FETCH (retires).
  - LOAD: go to WB.
- WB:
  - reg_write=1 unless inst_code[11:7]==0.
  - wb_sel: 1 for LOAD, 2 for JAL/JALR, else 0.
  - pc_write=1; pc_src is 1 for JAL, 2 for JALR, else 0.
  - Then go to FETCH (retires).
- TRAP:
  - All control outputs are 0 and illegal=1.
  - The FSM stays in TRAP until reset.
- instret:
  - Increments by 1 on every cycle with pc_write=1.
  - Wraps 0xFFFFFFFF→0 silently.
- Control outputs not listed for a state are 0 in that state.

## Timing
- Reset (asynchronous):
  - state=FETCH, illegal=0, instret=0.
  - While reset=1, every control output is forced to 0 combinationally, including imem_req.
- Control outputs are combinational from the state register and inst_code (Moore plus opcode decode). All registers update on the rising edge of clk.
- Minimum cycles per instruction (zero-wait memories):
  - BRANCH 3.
  - STORE 4; OP/OPIMM/LUI/AUIPC/JAL/JALR 4.
  - LOAD 5.
  - Each wait cycle adds 1.
- imem_ready or dmem_ready asserted outside FETCH or MEM is ignored.
- Reset mid-instruction abandons it: no pc_write, and instret does not count it.
- reset deassertion: FETCH with imem_req=1 on the first cycle after release.

## Test plan
- ADDI x1,x0,5 (0x00500093) with imem_ready held high:
  - States run FETCH→DECODE→EXEC→WB→FETCH.
  - imm_sel=1 from DECODE; reg_write=1, pc_src=0 in WB; instret 0→1.
- SW (0x00112223) with dmem_ready delayed 2 cycles:
  - MEM lasts 3 cycles with dmem_req=dmem_we=1.
  - imm_sel=2; pc_write only in the final MEM cycle; total 6 cycles.
- BEQ (0x00000463):
  - br_taken=1 → EXEC gives pc_write=1, pc_src=1, imm_sel=3.
  - br_taken=0 → pc_src=0.
  - Both take 3 cycles.
- JAL x1 (0x008000EF): WB gives wb_sel=2, pc_src=1, imm_sel=5, reg_write=1. Same JAL with rd=0 (0x0080006F) → reg_write=0.
- Opcode 0x0000007F:
  - DECODE→TRAP, illegal=1, all controls 0 for 20 cycles.
  - Assert reset → state=FETCH, illegal=0, instret=0.
- Reset asserted in MEM of a LOAD: pc_write never pulses and instret is unchanged. Separately, preload instret=0xFFFFFFFF via 2^32 retirements (or force) → next retirement yields 0.
